rlbp_s2p_capture: RTL and testbench
===================================

// Module: rlbp_s2p_capture
// PURPOSE
// - Downstream of the RLBP macro. Deserializes the RLBP serial output (serial_data_rlbp_out) into WIDTH-bit codes.
// - Buffers the codes in a DEPTH-entry FIFO and exposes them to the Caravel Wishbone bus as a small register slave.
// - Lets firmware read RLBP results without dedicating GPIO to the serial stream.
// PARAMETERS
// - WIDTH   8    bits per deserialized code (MSB received first)
// - DEPTH   8    FIFO entries; power of two, >= 2
// - BASE_NIB 4'h4  value wbs_adr_i[31:28] must match to select this slave
// PORTS
// - wb_clk_i    in   1     single clock, shared with Wishbone and the RLBP macro
// - wb_rst_ni   in   1     reset, synchronous, active-low
// - s_data_i    in   1     serial bit from the RLBP P2S stage
// - s_valid_i   in   1     qualifies s_data_i; one bit accepted per cycle while high
// - wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each   Wishbone strobe, cycle and write enable
// - wbs_sel_i   in   4     byte selects
// - wbs_adr_i   in   32    address; [31:28] selects the slave, [3:2] selects the register
// - wbs_dat_i   in   32    write data
// - wbs_ack_o   out  1     one-cycle acknowledge
// - wbs_dat_o   out  32    read data
// - irq_o       out  1     level interrupt (RLBP_S2P_IRQ_EN only; tied 0 otherwise)
// BEHAVIOUR
// - Reset (wb_rst_ni=0 at a clock edge):
//   - Clears shift register, bit counter, FIFO pointers, count, sticky OVF, CTRL.
//   - Outputs: wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
//   - A partial word in flight is discarded.
// - Deserializer:
//   - Active only while CTRL.EN=1.
//   - On each edge with s_valid_i=1: shift <= {shift[WIDTH-2:0], s_data_i}; bit counter increments.
//   - When the WIDTH-th bit is taken, the assembled word is pushed on that same edge and the counter wraps to 0.
//   - With EN=0, s_valid_i is ignored; the counter and partial word hold.
// - FIFO:
//   - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - Count is $clog2(DEPTH)+1 bits.
//   - A push when full (and no pop on the same edge) drops the word and sets sticky OVF. FIFO contents are unchanged.
//   - Push and pop on the same edge while full: both happen; count is unchanged and OVF is not set.
//   - Push and pop on the same edge while empty: the pop returns 0 and has no effect; the push happens.
// - Wishbone:
//   - access = cyc & stb & (adr[31:28]==BASE_NIB) & ~wbs_ack_o.
//   - The edge after an access: wbs_ack_o=1 for exactly one cycle, with wbs_dat_o valid on that cycle. Latency is 1 cycle.
//   - Unmatched addresses are never acknowledged.
//   - Write side effects apply on the access edge; writes need wbs_sel_i[0].
// - Register map:
//   - 0x0 DATA (RO): {zeros, head word}. Reading pops the FIFO. Reading when empty returns 0 with no pop.
//   - 0x4 STATUS: [15:8] count, [2] OVF, [1] full, [0] empty. Writing 1 to bit 2 clears OVF.
//     - If a set and a clear land on the same edge, the set wins.
//   - 0x8 CTRL (RW): [0] EN, [1] CLR (self-clearing), [15:8] THRESH.
//     - CLR=1 flushes the FIFO, the bit counter and OVF on the access edge. Any push on that edge is lost.
//   - 0xC ID (RO): 32'h524C_5331.
// CONFIGURATION
// - Macro RLBP_S2P_IRQ_EN.
// - Defined:
//   - irq_o is registered: irq_o <= EN & (count >= THRESH) & (THRESH != 0), or OVF.
//   - irq_o updates one cycle after the count changes.
// - Undefined:
//   - irq_o is tied 0 and no compare logic is built.
//   - THRESH still reads back as written.
// STRUCTURE
// - Package rlbp_s2p_pkg:
//   - register offsets REG_DATA, REG_STATUS, REG_CTRL, REG_ID
//   - ID constant
//   - STATUS/CTRL bit-index localparams
// - Sub-module rlbp_s2p_fifo (WIDTH, DEPTH):
//   - ports push, pop, wdata, rdata, count, full, empty, flush
//   - synchronous, first-word-fall-through
// - Top level holds the deserializer, register decode and IRQ logic.
// TESTING
// - Reset: hold wb_rst_ni=0 for 3 cycles with s_valid_i=1 -> STATUS reads 0x0000_0001, no ack appears during reset, irq_o=0.
// - Serial capture: EN=1; send bits 1,0,1,0,0,1,0,1 -> count=1; DATA read returns 0xA5; STATUS then reads empty.
// - Overflow: DEPTH=8; send 9 words 0x01..0x09 with no reads -> full=1, OVF=1; reads return 0x01..0x08, then 0.
//   - Write STATUS=0x4 -> OVF=0.
// - Simultaneous: FIFO full; pop DATA on the same edge the 8th bit of 0x3C arrives -> OVF stays 0, count stays 8, tail word is 0x3C.
// - Mid-word flush: after 4 bits, write CTRL=0x3 -> counter reset; 8 further bits 0xFF yield exactly one word 0xFF.
// - IRQ (RLBP_S2P_IRQ_EN): THRESH=3; push 3 words -> irq_o rises one cycle after the 3rd push; one DATA read -> irq_o=0.
//   - Without the macro: irq_o stays 0 throughout.

Source files
------------

// File: rtl/rlbp_s2p_pkg.sv
// ============================================================================
// Module : rlbp_s2p_pkg
// Brief  : Register offsets, ID constant and bit positions for rlbp_s2p_capture
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rlbp_s2p_pkg;

  // Register select, decoded from wbs_adr_i[3:2]
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_ID     = 2'd3
  } reg_sel_e;

  localparam logic [31:0] ID_VALUE = 32'h524C_5331;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_THR_LSB = 8;
  localparam int CTRL_THR_W   = 8;

endpackage

`default_nettype wire

// File: rtl/rlbp_s2p_fifo.sv
// ============================================================================
// Module : rlbp_s2p_fifo
// Brief  : Synchronous first-word-fall-through FIFO with flush
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rlbp_s2p_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_full_count);
  assign count = r_count;
  assign rdata = empty ? '0 : r_mem[r_rptr];

  // A pop frees the slot the same-edge push needs, so a full FIFO still accepts
  assign w_do_pop  = pop & ~flush & ~empty;
  assign w_do_push = push & ~flush & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/rlbp_s2p_capture.sv
// ============================================================================
// Module : rlbp_s2p_capture
// Brief  : RLBP serial-to-parallel capture, FIFO and Wishbone register slave.
//          `define RLBP_S2P_IRQ_EN builds the threshold/overflow interrupt.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rlbp_s2p_capture
  import rlbp_s2p_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         DEPTH    = 8,
  parameter logic [3:0] BASE_NIB = 4'h4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        s_data_i,
  input  logic        s_valid_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int BCW = $clog2(WIDTH);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [BCW-1:0] c_last_bit = BCW'(WIDTH - 1);

  logic [WIDTH-1:0]      r_shift;
  logic [BCW-1:0]        r_bitcnt;
  logic                  r_en;
  logic [CTRL_THR_W-1:0] r_thresh;
  logic                  r_ovf;
  logic                  r_ack;
  logic [31:0]           r_dat;

  logic                  w_access;
  logic                  w_wr;
  logic                  w_rd;
  reg_sel_e              w_reg;
  logic                  w_clr;
  logic                  w_ovf_clr;
  logic                  w_bit_take;
  logic                  w_word_done;
  logic [WIDTH-1:0]      w_word;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf_set;
  logic [WIDTH-1:0]      w_fifo_rdata;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [31:0]           w_rdval;
  logic                  w_unused;

  assign w_access = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB) & ~r_ack;
  assign w_reg    = reg_sel_e'(wbs_adr_i[3:2]);
  assign w_wr     = w_access & wbs_we_i & wbs_sel_i[0];
  assign w_rd     = w_access & ~wbs_we_i;

  assign w_clr     = w_wr & (w_reg == REG_CTRL) & wbs_dat_i[CTRL_CLR];
  assign w_ovf_clr = w_wr & (w_reg == REG_STATUS) & wbs_dat_i[STAT_OVF];

  assign w_bit_take  = r_en & s_valid_i;
  assign w_word_done = w_bit_take & (r_bitcnt == c_last_bit);
  assign w_word      = {r_shift[WIDTH-2:0], s_data_i};

  assign w_push    = w_word_done & ~w_clr;
  assign w_pop     = w_rd & (w_reg == REG_DATA) & ~w_empty;
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni || w_clr) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_bit_take) begin
      r_shift  <= w_word;
      r_bitcnt <= w_word_done ? '0 : r_bitcnt + 1'b1;
    end
  end

  rlbp_s2p_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .flush (w_clr),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_word),
    .rdata (w_fifo_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // A same-edge set outranks a firmware clear; CLR cannot collide with a set
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr || w_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_en     <= 1'b0;
      r_thresh <= '0;
    end else if (w_wr && (w_reg == REG_CTRL)) begin
      r_en     <= wbs_dat_i[CTRL_EN];
      r_thresh <= wbs_dat_i[CTRL_THR_LSB +: CTRL_THR_W];
    end
  end

  always_comb begin
    w_rdval = '0;
    case (w_reg)
      REG_DATA:   w_rdval[WIDTH-1:0] = w_fifo_rdata;
      REG_STATUS: begin
        w_rdval[STAT_CNT_LSB +: CW] = w_count;
        w_rdval[STAT_OVF]           = r_ovf;
        w_rdval[STAT_FULL]          = w_full;
        w_rdval[STAT_EMPTY]         = w_empty;
      end
      REG_CTRL: begin
        w_rdval[CTRL_EN]                       = r_en;
        w_rdval[CTRL_THR_LSB +: CTRL_THR_W]    = r_thresh;
      end
      default:    w_rdval = ID_VALUE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_access ? w_rdval : '0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

`ifdef RLBP_S2P_IRQ_EN
  logic r_irq;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_en & (32'(w_count) >= 32'(r_thresh)) & (r_thresh != '0)) | r_ovf;
    end
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  assign w_unused = &{1'b0, wbs_adr_i[27:4], wbs_adr_i[1:0], wbs_sel_i[3:1],
                      wbs_dat_i[31:16], wbs_dat_i[7:3]};

endmodule

`default_nettype wire

// File: tb/tb_rlbp_s2p_capture.sv
// ============================================================================
// Module : tb_rlbp_s2p_capture
// Brief  : Scoreboard bench for rlbp_s2p_capture (honours RLBP_S2P_IRQ_EN)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rlbp_s2p_capture;

  localparam logic [31:0] A_DATA   = 32'h4000_0000;
  localparam logic [31:0] A_STATUS = 32'h4000_0004;
  localparam logic [31:0] A_CTRL   = 32'h4000_0008;
  localparam logic [31:0] A_ID     = 32'h4000_000C;

`ifdef RLBP_S2P_IRQ_EN
  localparam logic c_irq_on = 1'b1;
`else
  localparam logic c_irq_on = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_data;
  logic        s_valid;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  rlbp_s2p_capture #(.WIDTH(8), .DEPTH(8), .BASE_NIB(4'h4)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .s_data_i  (s_data),
    .s_valid_i (s_valid),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .irq_o     (irq)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits a bounded number of edges for ack, then releases the bus and idles one cycle
  task automatic wait_ack(input string tag, input bit is_rd);
    bit          got;
    logic [31:0] exp;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check_val({tag, "_ack"}, {31'b0, got}, 32'd1);
    if (is_rd) begin
      exp = sb_q.pop_front();
      check_val(tag, rdat, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    sb_q.push_back(exp);
    adr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    wait_ack(tag, 1'b1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    adr = a; wdat = d; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    wait_ack(tag, 1'b0);
  endtask

  // Sends the top n bits of w, MSB first, one per cycle
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      s_valid = 1'b1; s_data = w[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b1; s_data = 1'b1;
    adr = A_STATUS; wdat = '0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("rst_ack", {31'b0, ack}, 32'd0);
      check_val("rst_irq", {31'b0, irq}, 32'd0);
    end
    check_val("rst_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0; s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    wb_read(A_STATUS, 32'h0000_0001, "rst_status");
    wb_read(A_ID,     32'h524C_5331, "id");
    wb_read(A_CTRL,   32'h0000_0000, "ctrl_rst");

    adr = 32'h3000_0004; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("nomatch_ack", {31'b0, ack}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // Basic capture
    wb_write(A_CTRL, 32'h0000_0001, "en");
    send_bits(8'hA5, 8);
    wb_read(A_STATUS, 32'h0000_0100, "cap_status");
    wb_read(A_DATA,   32'h0000_00A5, "cap_data");
    wb_read(A_STATUS, 32'h0000_0001, "cap_empty");
    wb_read(A_DATA,   32'h0000_0000, "empty_data");

    // Overflow
    for (int w = 1; w <= 9; w++) send_bits(8'(w), 8);
    wb_read(A_STATUS, 32'h0000_0806, "ovf_status");
    check_val("ovf_irq", {31'b0, irq}, {31'b0, c_irq_on});
    for (int w = 1; w <= 8; w++) wb_read(A_DATA, 32'(w), "ovf_data");
    wb_read(A_DATA,   32'h0000_0000, "ovf_drain");
    wb_read(A_STATUS, 32'h0000_0005, "ovf_sticky");
    wb_write(A_STATUS, 32'h0000_0004, "ovf_clr");
    wb_read(A_STATUS, 32'h0000_0001, "ovf_cleared");
    check_val("ovf_clr_irq", {31'b0, irq}, 32'd0);

    // Simultaneous pop and push while full
    for (int w = 0; w < 8; w++) send_bits(8'h11 + 8'(w), 8);
    send_bits(8'h3C, 7);
    s_valid = 1'b1; s_data = 1'b0;
    sb_q.push_back(32'h0000_0011);
    adr = A_DATA; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    wait_ack("sim_data", 1'b1);
    wb_read(A_STATUS, 32'h0000_0802, "sim_status");
    check_val("sim_irq", {31'b0, irq}, 32'd0);
    for (int w = 1; w < 8; w++) wb_read(A_DATA, 32'h11 + 32'(w), "sim_data_n");
    wb_read(A_DATA,   32'h0000_003C, "sim_tail");
    wb_read(A_STATUS, 32'h0000_0001, "sim_empty");

    // Mid-word flush
    send_bits(8'hA0, 4);
    wb_write(A_CTRL, 32'h0000_0003, "clr");
    wb_read(A_CTRL,   32'h0000_0001, "clr_self");
    send_bits(8'hFF, 8);
    wb_read(A_STATUS, 32'h0000_0100, "flush_status");
    wb_read(A_DATA,   32'h0000_00FF, "flush_data");
    wb_read(A_STATUS, 32'h0000_0001, "flush_empty");

    // Threshold interrupt
    wb_write(A_CTRL, 32'h0000_0301, "thr");
    wb_read(A_CTRL,  32'h0000_0301, "thr_rb");
    send_bits(8'h31, 8);
    send_bits(8'h32, 8);
    check_val("irq_two", {31'b0, irq}, 32'd0);
    send_bits(8'h33, 7);
    s_valid = 1'b1; s_data = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check_val("irq_push_edge", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check_val("irq_rise", {31'b0, irq}, {31'b0, c_irq_on});
    wb_read(A_DATA, 32'h0000_0031, "irq_pop");
    check_val("irq_fall", {31'b0, irq}, 32'd0);

    if (sb_q.size() != 0) check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
